// File: rtl/hmac_msg_padder.sv
`default_nettype none
// ============================================================================
// Module      : hmac_msg_padder
// Description : Applies SHA-384 padding to a 32-bit big-endian message stream
//               and drives the blocks into the HMAC-384 register port.
// Revision    : 1.0 - initial release
// ============================================================================
module hmac_msg_padder #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_CTRL     = ADDR_WIDTH'(32'h0000_0010),
    parameter logic [ADDR_WIDTH-1:0] ADDR_STATUS   = ADDR_WIDTH'(32'h0000_0018),
    parameter logic [ADDR_WIDTH-1:0] ADDR_BLOCK0   = ADDR_WIDTH'(32'h0000_0080),
    parameter int                    INIT_BIT      = 0,
    parameter int                    NEXT_BIT      = 1,
    parameter int                    SETTLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  empty_msg,
    input  logic                  msg_valid,
    output logic                  msg_ready,
    input  logic [31:0]           msg_data,
    input  logic                  msg_last,
    input  logic [1:0]            msg_bytes,
    output logic                  hmac_cs,
    output logic                  hmac_we,
    output logic [ADDR_WIDTH-1:0] hmac_address,
    output logic [31:0]           hmac_write_data,
    input  logic [31:0]           hmac_read_data,
    output logic                  busy,
    output logic                  done
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RDY = 3'd1;
    localparam logic [2:0] S_FILL     = 3'd2;
    localparam logic [2:0] S_PAD      = 3'd3;
    localparam logic [2:0] S_LEN      = 3'd4;
    localparam logic [2:0] S_KICK     = 3'd5;
    localparam logic [2:0] S_SETTLE   = 3'd6;
    localparam logic [2:0] S_TAG_WAIT = 3'd7;

    logic [2:0]            r_state;
    logic [4:0]            r_idx;
    logic [60:0]           r_bytecnt;
    logic                  r_first;
    logic                  r_empty;
    logic                  r_last_seen;
    logic                  r_pad_done;
    logic                  r_len_done;
    logic                  r_done;
    logic [SW-1:0]         r_settle;

    logic [2:0]            w_last_bytes;
    logic [31:0]           w_last_word;
    logic [63:0]           w_len;
    logic [ADDR_WIDTH-1:0] w_blk_addr;
    logic                  w_unused;

    assign w_last_bytes = (msg_bytes == 2'd0) ? 3'd4 : {1'b0, msg_bytes};
    assign w_len        = {r_bytecnt, 3'b000};
    assign w_blk_addr   = ADDR_BLOCK0 + ADDR_WIDTH'({r_idx, 2'b00});
    assign w_unused     = ^hmac_read_data[31:2];

    // Terminate a short final word in place: 0x80 after the last valid byte.
    always_comb begin
        case (msg_bytes)
            2'd1:    w_last_word = {msg_data[31:24], 8'h80, 16'h0000};
            2'd2:    w_last_word = {msg_data[31:16], 8'h80, 8'h00};
            2'd3:    w_last_word = {msg_data[31:8], 8'h80};
            default: w_last_word = msg_data;
        endcase
    end

    assign msg_ready = (r_state == S_FILL);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

    always_comb begin
        hmac_cs         = 1'b0;
        hmac_we         = 1'b0;
        hmac_address    = '0;
        hmac_write_data = '0;
        case (r_state)
            S_WAIT_RDY, S_TAG_WAIT: begin
                hmac_cs      = 1'b1;
                hmac_address = ADDR_STATUS;
            end
            S_FILL: begin
                if (msg_valid) begin
                    hmac_cs         = 1'b1;
                    hmac_we         = 1'b1;
                    hmac_address    = w_blk_addr;
                    hmac_write_data = msg_last ? w_last_word : msg_data;
                end
            end
            S_PAD: begin
                hmac_cs         = 1'b1;
                hmac_we         = 1'b1;
                hmac_address    = w_blk_addr;
                hmac_write_data = r_pad_done ? 32'h0000_0000 : 32'h8000_0000;
            end
            S_LEN: begin
                hmac_cs         = 1'b1;
                hmac_we         = 1'b1;
                hmac_address    = w_blk_addr;
                hmac_write_data = (r_idx == 5'd30) ? w_len[63:32] :
                                  (r_idx == 5'd31) ? w_len[31:0]  : 32'h0000_0000;
            end
            S_KICK: begin
                hmac_cs         = 1'b1;
                hmac_we         = 1'b1;
                hmac_address    = ADDR_CTRL;
                hmac_write_data = r_first ? (32'd1 << INIT_BIT) : (32'd1 << NEXT_BIT);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_bytecnt   <= '0;
            r_first     <= 1'b0;
            r_empty     <= 1'b0;
            r_last_seen <= 1'b0;
            r_pad_done  <= 1'b0;
            r_len_done  <= 1'b0;
            r_done      <= 1'b0;
            r_settle    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_WAIT_RDY;
                        r_first     <= 1'b1;
                        r_idx       <= '0;
                        r_bytecnt   <= '0;
                        r_empty     <= empty_msg;
                        r_last_seen <= 1'b0;
                        r_pad_done  <= 1'b0;
                        r_len_done  <= 1'b0;
                    end
                end
                S_WAIT_RDY: begin
                    if (hmac_read_data[0]) begin
                        r_state <= (r_empty || r_last_seen) ? S_PAD : S_FILL;
                    end
                end
                S_FILL: begin
                    if (msg_valid) begin
                        r_idx <= r_idx + 5'd1;
                        if (!msg_last) begin
                            r_bytecnt <= r_bytecnt + 61'd4;
                            if (r_idx == 5'd31) begin
                                r_state <= S_KICK;
                            end
                        end else begin
                            r_last_seen <= 1'b1;
                            r_bytecnt   <= r_bytecnt + 61'(w_last_bytes);
                            r_pad_done  <= (msg_bytes != 2'd0);
                            // A full block always goes out first; a short word
                            // ending at word 27 leaves room for the length only.
                            if (r_idx == 5'd31) begin
                                r_state <= S_KICK;
                            end else if (msg_bytes != 2'd0 && r_idx == 5'd27) begin
                                r_state <= S_LEN;
                            end else begin
                                r_state <= S_PAD;
                            end
                        end
                    end
                end
                S_PAD: begin
                    r_idx      <= r_idx + 5'd1;
                    r_pad_done <= 1'b1;
                    if (r_idx == 5'd31) begin
                        r_state <= S_KICK;
                    end else if (r_idx == 5'd27) begin
                        r_state <= S_LEN;
                    end
                end
                S_LEN: begin
                    r_idx <= r_idx + 5'd1;
                    if (r_idx == 5'd31) begin
                        r_len_done <= 1'b1;
                        r_state    <= S_KICK;
                    end
                end
                S_KICK: begin
                    r_first  <= 1'b0;
                    r_idx    <= '0;
                    r_settle <= '0;
                    r_state  <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
                        r_state <= r_len_done ? S_TAG_WAIT : S_WAIT_RDY;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                S_TAG_WAIT: begin
                    if (hmac_read_data[1:0] == 2'b11) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hmac_msg_padder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hmac_msg_padder
// Description : Random and directed messages against a byte-level SHA-384
//               padding model, with a simple HMAC register-block responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hmac_msg_padder;

    localparam logic [31:0] A_CTRL   = 32'h0000_0010;
    localparam logic [31:0] A_STATUS = 32'h0000_0018;
    localparam logic [31:0] A_BLK0   = 32'h0000_0080;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic        empty_msg = 1'b0;
    logic        msg_valid = 1'b0;
    logic [31:0] msg_data  = '0;
    logic        msg_last  = 1'b0;
    logic [1:0]  msg_bytes = '0;
    logic        msg_ready, hmac_cs, hmac_we, busy, done;
    logic [31:0] hmac_address, hmac_write_data, hmac_read_data;

    int   total = 0;
    int   bad   = 0;
    logic rdy   = 1'b1;
    logic tagv  = 1'b0;
    logic hold  = 1'b0;
    int   hcnt  = 0;

    hmac_msg_padder #(
        .ADDR_WIDTH   (32),
        .ADDR_CTRL    (A_CTRL),
        .ADDR_STATUS  (A_STATUS),
        .ADDR_BLOCK0  (A_BLK0),
        .INIT_BIT     (0),
        .NEXT_BIT     (1),
        .SETTLE_CYCLES(3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .empty_msg      (empty_msg),
        .msg_valid      (msg_valid),
        .msg_ready      (msg_ready),
        .msg_data       (msg_data),
        .msg_last       (msg_last),
        .msg_bytes      (msg_bytes),
        .hmac_cs        (hmac_cs),
        .hmac_we        (hmac_we),
        .hmac_address   (hmac_address),
        .hmac_write_data(hmac_write_data),
        .hmac_read_data (hmac_read_data),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    always_comb begin
        hmac_read_data = '0;
        if (hmac_cs && !hmac_we && hmac_address == A_STATUS)
            hmac_read_data = {30'b0, tagv, rdy && !hold};
    end

    // Hash engine stand-in: busy for a few cycles after every CTRL write.
    always @(posedge clk) begin
        if (hmac_cs && hmac_we && hmac_address == A_CTRL) begin
            rdy  <= 1'b0;
            tagv <= 1'b0;
            hcnt <= $urandom_range(2, 6);
        end else if (hcnt > 0) begin
            hcnt <= hcnt - 1;
            if (hcnt == 1) begin
                rdy  <= 1'b1;
                tagv <= 1'b1;
            end
        end
    end

    task automatic chk(input string tn, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tn, tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] w4(input byte unsigned q[$], input int p);
        return {q[p], q[p+1], q[p+2], q[p+3]};
    endfunction

    task automatic run_msg(input string name, input int nbytes, input bit use_empty, input bit abc,
                           input int hold_n, input int abort_at);
        byte unsigned mb[$];
        byte unsigned pb[$];
        logic [31:0]  words[$];
        logic [63:0]  exp_q[$];
        logic [63:0]  log_q[$];
        logic [127:0] bits;
        int nwords, widx, nblk, nctrl, held, rel_cyc;
        bit seen3, exp_done, got_done, aborted;

        if (abc) begin
            mb.push_back(8'h61); mb.push_back(8'h62); mb.push_back(8'h63);
        end else begin
            for (int i = 0; i < nbytes; i++) mb.push_back(8'($urandom));
        end
        // Reference padding: msg || 0x80 || zeros || 128-bit bit length.
        pb = mb;
        pb.push_back(8'h80);
        while (pb.size() % 128 != 112) pb.push_back(8'h00);
        bits = 128'(nbytes) * 128'd8;
        for (int i = 15; i >= 0; i--) pb.push_back(bits[8*i +: 8]);
        nblk = pb.size() / 128;
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 32; i++) exp_q.push_back({A_BLK0 + 32'(4*i), w4(pb, b*128 + 4*i)});
            exp_q.push_back({A_CTRL, (b == 0) ? 32'h1 : 32'h2});
        end
        nwords = (nbytes + 3) / 4;
        for (int w = 0; w < nwords; w++) begin
            logic [31:0] x;
            for (int j = 0; j < 4; j++)
                x[31-8*j -: 8] = (4*w + j < nbytes) ? mb[4*w + j] : 8'($urandom);
            words.push_back(x);
        end

        widx = 0; nctrl = 0; held = 0; rel_cyc = -10;
        seen3 = 0; got_done = 0; aborted = 0;
        hold = (hold_n > 0);
        for (int cyc = 0; cyc < 6000 && !got_done && !aborted; cyc++) begin
            start     = (cyc == 0) || (cyc == 3);
            empty_msg = (cyc == 0) ? use_empty : 1'b1;
            if (!use_empty && widx < nwords && $urandom_range(0, 3) != 0) begin
                msg_valid = 1'b1;
                msg_data  = words[widx];
                msg_last  = (widx == nwords - 1);
                msg_bytes = msg_last ? 2'(nbytes % 4) : 2'($urandom);
            end else begin
                msg_valid = 1'b0;
                msg_data  = $urandom;
                msg_last  = 1'($urandom);
                msg_bytes = 2'($urandom);
            end
            @(negedge clk);
            exp_done = seen3;
            chk(name, "done", 64'(done), 64'(exp_done));
            chk(name, "busy", 64'(busy), 64'((cyc > 0) && !exp_done));
            if (!hmac_cs) chk(name, "idle_bus", {hmac_address, hmac_write_data}, 64'h0);
            if (use_empty) chk(name, "ready_empty", 64'(msg_ready), 64'h0);
            if (hold && cyc > 0) begin
                chk(name, "hold_poll", 64'({hmac_cs, hmac_we, hmac_address == A_STATUS, msg_ready}), 64'b1010);
                held++;
            end
            if (cyc == rel_cyc + 1) chk(name, "ready_seen_cycle", 64'(msg_ready), 64'h0);
            if (cyc == rel_cyc + 2) chk(name, "fill_after_ready", 64'(msg_ready), 64'h1);
            seen3 = (nctrl == nblk) && hmac_cs && !hmac_we && hmac_address == A_STATUS
                    && hmac_read_data[1:0] == 2'b11;
            if (hmac_cs && hmac_we) begin
                log_q.push_back({hmac_address, hmac_write_data});
                if (hmac_address == A_CTRL) nctrl++;
            end
            if (msg_valid && msg_ready) widx++;
            if (done) got_done = 1;
            if (abort_at > 0 && widx == abort_at) begin
                @(posedge clk); #1;
                reset = 1'b1; msg_valid = 1'b0; start = 1'b0;
                @(negedge clk);
                chk(name, "abort_outs", 64'({hmac_cs, busy, msg_ready}), 64'h0);
                @(posedge clk); #1;
                reset = 1'b0;
                aborted = 1;
            end else begin
                @(posedge clk); #1;
            end
            if (hold && held >= hold_n) begin
                hold    = 1'b0;
                rel_cyc = cyc;
            end
        end
        msg_valid = 1'b0;
        start     = 1'b0;
        hold      = 1'b0;
        if (aborted) return;
        if (!got_done) chk(name, "timeout", 64'h0, 64'h1);
        chk(name, "write_count", 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            chk(name, $sformatf("wr%0d", i), log_q[i], exp_q[i]);
        if (abc && log_q.size() >= 33) begin
            chk(name, "abc_block0", log_q[0], {A_BLK0, 32'h6162_6380});
            chk(name, "abc_block31", log_q[31], {A_BLK0 + 32'd124, 32'h0000_0018});
            chk(name, "abc_ctrl", log_q[32], {A_CTRL, 32'h0000_0001});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", "outs", {27'b0, hmac_cs, hmac_we, busy, done, msg_ready, hmac_address ^ hmac_write_data},
            64'h0);
        chk("reset", "addr_data", {hmac_address, hmac_write_data}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_msg("abc",         3,   1'b0, 1'b1, 0,  0);
        run_msg("len112",      112, 1'b0, 1'b0, 0,  0);
        run_msg("len111",      111, 1'b0, 1'b0, 0,  0);
        run_msg("empty",       0,   1'b1, 1'b0, 0,  0);
        run_msg("hold",        40,  1'b0, 1'b0, 10, 0);
        run_msg("abort",       200, 1'b0, 1'b0, 0,  5);
        run_msg("after_abort", 20,  1'b0, 1'b0, 0,  0);
        run_msg("len117",      117, 1'b0, 1'b0, 0,  0);
        run_msg("len128",      128, 1'b0, 1'b0, 0,  0);
        for (int t = 0; t < 5; t++)
            run_msg($sformatf("rand%0d", t), $urandom_range(1, 300), 1'b0, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hmac_msg_padder.md
Name: hmac_msg_padder

Overview:
- Upstream feeder for the HMAC-384 register block. Accepts a 32-bit big-endian message stream and applies SHA-384 padding: 0x80 byte, zero fill, then a 128-bit length.
- Acts as a bus master on the HMAC 32-bit register port. Writes the BLOCK0..31 words, writes CTRL (INIT for the first block, NEXT for later blocks), and polls STATUS between blocks.
- Pulses done once the final tag is valid. Firmware or the KV path then reads the tag.

Parameters:
- ADDR_WIDTH, 32, width of hmac_address.
- ADDR_CTRL, HMAC_ADDR_CTRL, CTRL register address.
- ADDR_STATUS, HMAC_ADDR_STATUS, STATUS register address; bit0 = ready, bit1 = tag_valid.
- ADDR_BLOCK0, HMAC_ADDR_BLOCK0, BLOCK0 address; word i is at ADDR_BLOCK0 + 4*i.
- INIT_BIT, HMAC_CTRL_INIT_BIT, CTRL bit position for INIT.
- NEXT_BIT, HMAC_CTRL_NEXT_BIT, CTRL bit position for NEXT.
- SETTLE_CYCLES, 3, idle cycles after a CTRL write before STATUS is trusted; minimum 3.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a message; ignored while busy
- empty_msg  in  1  sampled with start; 1 = zero-length message, no stream words are taken
- msg_valid  in  1  stream word valid
- msg_ready  out  1  stream word accepted when msg_valid & msg_ready
- msg_data  in  32  message word; first byte in [31:24]
- msg_last  in  1  marks the final word
- msg_bytes  in  2  valid bytes in the last word, left-justified; 0 encodes 4; ignored when msg_last=0
- hmac_cs  out  1  register access strobe
- hmac_we  out  1  1 = write, 0 = read
- hmac_address  out  ADDR_WIDTH  register address
- hmac_write_data  out  32  write data
- hmac_read_data  in  32  read data, combinational in the same cycle as the read strobe
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse when the final tag is valid

Behaviour:
- Reset: state IDLE; all outputs 0; word index, byte counter and first-block flag cleared. Reset mid-operation aborts immediately. No further bus cycles are issued, and HMAC register contents are left as they are.
- At most one bus access per cycle. hmac_cs is 0 whenever the block is not accessing; address and data are 0 when hmac_cs=0.
- IDLE: on start go to WAIT_RDY with first=1, idx=0, bytecnt=0. Latch empty_msg.
- WAIT_RDY: read ADDR_STATUS every cycle. When read_data[0]=1, go to FILL, or to PAD if the message is already exhausted.
- FILL: msg_ready=1 only in this state.
  - Each accepted word is written to BLOCK[idx] in the same cycle; idx increments and bytecnt += 4.
  - A non-last word at idx 31 goes to KICK.
  - A last word with k<4 valid bytes: byte k is set to 0x80 and the lower bytes are zeroed before the write; bytecnt += k. Then go to PAD with pad_done=1.
  - A last word with k=4 goes to PAD with pad_done=0.
  - For empty_msg, FILL is skipped.
- PAD, one write per cycle:
  - If pad_done=0, write 0x80000000 and set pad_done.
  - Otherwise write zeros until idx=28, then go to LEN.
  - If idx>28 after the 0x80 word, zero-fill through idx 31 and go to KICK. The length goes in an extra block.
- LEN: write words 28..31. Words 28 and 29 are 0. Word 30 is L[63:32] and word 31 is L[31:0], where L = bytecnt*8 (64-bit). bytecnt is 61 bits, so the message limit is 2^61-1 bytes. Then KICK.
- KICK: write ADDR_CTRL with INIT_BIT set if first=1, else NEXT_BIT. Clear first, set idx=0, go to SETTLE.
- SETTLE: SETTLE_CYCLES cycles with no access. Then:
  - if more data or padding remains, go to WAIT_RDY;
  - otherwise go to TAG_WAIT.
- TAG_WAIT: read STATUS every cycle. When read_data[1:0]=2'b11, pulse done for one cycle and return to IDLE; busy drops in the same cycle.
- Stream words presented outside FILL are held off (msg_ready=0), never dropped.
- start while busy is ignored.
- msg_last with msg_valid=0 has no effect.
- Latency: a 1-block message with N words takes at least 1 (poll) + 32 + 1 + SETTLE_CYCLES cycles, plus hash time, to reach TAG_WAIT.

Test Plan:
- "abc": word 0x61626300, msg_bytes=3, last; STATUS=3 → BLOCK0=0x61626380, BLOCK1..30=0, BLOCK31=0x00000018, then CTRL with INIT only; done one cycle after STATUS=3 is seen in TAG_WAIT.
- 112-byte message (28 words, last, bytes=0) → block0: words 0..27 data, word28=0x80000000, words 29..31=0, CTRL INIT; block1: words 0..30=0, word31=0x00000380, CTRL NEXT; exactly 2 CTRL writes.
- 111-byte message (last word bytes=3) → single block; word27 low byte 0x80; word31=0x00000378; 1 CTRL write.
- empty_msg=1 with start → BLOCK0=0x80000000, all other words 0 including BLOCK31; msg_ready never asserted.
- STATUS ready held at 0 for 10 cycles in WAIT_RDY → 10 consecutive STATUS reads, no BLOCK writes, msg_ready=0; FILL begins the cycle after ready=1.
- reset asserted mid-FILL at idx=5 → the next cycle shows hmac_cs=0, busy=0, msg_ready=0; a new start then writes from BLOCK0 with INIT.
